// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and constants for the fetch stage and its IF/ID register.
package rv_pipe_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        DISCARD,
        HELD
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:   NOP_INSTR,
        pc:      '0,
        pcplus4: '0,
        valid:   1'b0
    };

    // Sequential PC; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port.
interface fetch_stage_if import rv_pipe_pkg::*;;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module if_id_reg import rv_pipe_pkg::*; (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            load,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    output if_id_t          q
);

    // Decode-side register; resets to a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= IF_ID_BUBBLE;
        end else if (flush) begin
            q <= IF_ID_BUBBLE;
        end else if (!stall) begin
            if (load) begin
                q <= '{instr: instr, pc: pc, pcplus4: pc_plus4(pc), valid: 1'b1};
            end else begin
                q <= IF_ID_BUBBLE;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns PCF, drives the imem request, parks one word while decode stalls,
// and drops the in-flight word when EX redirects.
module fetch_stage import rv_pipe_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [XLEN-1:0] hold_instr_q, hold_pc_q;
    logic            req_q;
    logic            hold_load;
    logic            d_load;
    logic [XLEN-1:0] d_instr, d_pc;
    logic            ack;
    if_id_t          d_q;

    // An ack only counts against a request we actually made (ignores stragglers after reset).
    assign ack = req_q & imem.imem_ack;

    // PCF is only moved on ack/redirect, so it doubles as a stable fetch address.
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pcf_q;
    assign PCF            = pcf_q;

    // State, PC, redirect target and request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pcf_q   <= RESET_PC;
            tgt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            tgt_q   <= tgt_d;
            req_q   <= (state_d != HELD);
        end
    end

    // One-entry hold buffer for a word that arrived while decode was stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else if (hold_load) begin
            hold_instr_q <= imem.imem_rdata;
            hold_pc_q    <= pcf_q;
        end
    end

    // Next state: redirect beats ack beats stall.
    always_comb begin
        state_d   = state_q;
        pcf_d     = pcf_q;
        tgt_d     = tgt_q;
        hold_load = 1'b0;
        d_load    = 1'b0;
        d_instr   = imem.imem_rdata;
        d_pc      = pcf_q;
        unique case (state_q)
            FETCH: begin
                if (PCSrcE) begin
                    if (ack) begin
                        pcf_d = PCTargetE;
                    end else begin
                        tgt_d   = PCTargetE;
                        state_d = DISCARD;
                    end
                end else if (ack) begin
                    pcf_d = pc_plus4(pcf_q);
                    if (StallD) begin
                        hold_load = 1'b1;
                        state_d   = HELD;
                    end else begin
                        d_load = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (ack) begin
                    pcf_d   = PCSrcE ? PCTargetE : tgt_q;
                    state_d = FETCH;
                end else if (PCSrcE) begin
                    tgt_d = PCTargetE;
                end
            end
            HELD: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = FETCH;
                end else if (!StallD) begin
                    d_load  = 1'b1;
                    d_instr = hold_instr_q;
                    d_pc    = hold_pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .reset (reset),
        .stall (StallD),
        .flush (FlushD),
        .load  (d_load),
        .instr (d_instr),
        .pc    (d_pc),
        .q     (d_q)
    );

    assign InstrD   = d_q.instr;
    assign PCD      = d_q.pc;
    assign PCPlus4D = d_q.pcplus4;
    assign ValidD   = d_q.valid;

endmodule
